mem_port_arbiter: RTL and testbench

//   Shares one memory_control instance between two requesters: port 0 = instruction fetch, port 1 = data load/store.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Turns a port index into the matching per-port pulse vector.
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Combinational winner selection.
  always_comb begin
    valid = |req;
    grant = PORT_FETCH;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[PORT_DATA]) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_control between instruction fetch (port 0) and data
// load/store (port 1). One transaction outstanding at a time; the winner's
// command is latched, strobed once, and answered with done (or done+err on
// timeout).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          port_req,
  input  logic [1:0]          port_we,
  input  logic [2*ADDR_W-1:0] port_addr,
  input  logic [2*DATA_W-1:0] port_wdata,
  output logic [DATA_W-1:0]   port_rdata,
  output logic [1:0]          port_done,
  output logic [1:0]          port_err,
  output logic                busy,
  output logic                mem_request,
  output logic                mem_req_type,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_write_done,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  // Leaving WAIT when the timer would step onto TIMEOUT_CYCLES-1 puts the
  // error response exactly TIMEOUT_CYCLES cycles after the strobe.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

  arb_state_e         state;
  arb_state_e         state_next;
  logic [TIMER_W-1:0] timer;
  logic               winner;
  logic               last_grant;
  logic               grant;
  logic               grant_valid;
  logic               completion;
  logic               timed_out;
  logic               accept;
  logic               capture_rdata;
  logic               mem_request_d;
  logic               busy_d;
  logic [1:0]         port_done_d;
  logic [1:0]         port_err_d;

  rr_arbiter2 u_rr (
    .req        (port_req),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  // Only the flag matching the latched command type counts as completion.
  always_comb begin
    completion = (mem_req_type == REQ_WRITE) ? mem_write_done : mem_ready;
    timed_out  = !completion && (timer == TIMER_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (completion || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; flags outside WAIT are ignored.
  always_comb begin
    mem_request_d = 1'b0;
    port_done_d   = 2'b00;
    port_err_d    = 2'b00;
    accept        = 1'b0;
    capture_rdata = 1'b0;
    busy_d        = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept        = 1'b1;
          mem_request_d = 1'b1;
        end
      end
      WAIT: begin
        if (completion) begin
          port_done_d   = port_onehot(winner);
          capture_rdata = (mem_req_type == REQ_READ);
        end else if (timed_out) begin
          port_done_d = port_onehot(winner);
          port_err_d  = port_onehot(winner);
        end
      end
      default: ;
    endcase
  end

  // Output registers and command latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_request  <= 1'b0;
      busy         <= 1'b0;
      port_done    <= 2'b00;
      port_err     <= 2'b00;
      port_rdata   <= '0;
      mem_req_type <= REQ_READ;
      mem_req_addr <= '0;
      mem_wdata    <= '0;
      winner       <= PORT_FETCH;
    end else begin
      mem_request <= mem_request_d;
      busy        <= busy_d;
      port_done   <= port_done_d;
      port_err    <= port_err_d;
      if (accept) begin
        winner       <= grant;
        mem_req_type <= port_we[grant];
        mem_req_addr <= grant ? port_addr[ADDR_W +: ADDR_W] : port_addr[0 +: ADDR_W];
        mem_wdata    <= grant ? port_wdata[DATA_W +: DATA_W] : port_wdata[0 +: DATA_W];
      end
      if (capture_rdata) begin
        port_rdata <= mem_rdata;
      end
    end
  end

  // Saturating WAIT timer, cleared while the strobe is out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT && timer != TIMER_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  // Round-robin history, updated once the response has been delivered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= PORT_DATA;
    end else if (state == RESP) begin
      last_grant <= winner;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions
// followed by hand-written tie, timeout, reset and wrong-flag sequences.
// Expected strobes and responses are queued when a command is driven and
// popped by a monitor when the DUT produces them.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          port_req;
  logic [1:0]          port_we;
  logic [2*ADDR_W-1:0] port_addr;
  logic [2*DATA_W-1:0] port_wdata;
  logic [DATA_W-1:0]   port_rdata;
  logic [1:0]          port_done;
  logic [1:0]          port_err;
  logic                busy;
  logic                mem_request;
  logic                mem_req_type;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ready;
  logic                mem_write_done;
  logic [DATA_W-1:0]   mem_rdata;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } strobe_t;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rdata;
  } resp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_data;
    int          delay;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  strobe_t     exp_strobe_q[$];
  resp_t       exp_resp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  bit          mon_en     = 1'b0;
  int          resp_delay = 0;
  logic [15:0] resp_data  = 16'h0000;
  bit          wrong_flag = 1'b0;
  logic [15:0] model_rdata;

  mem_port_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .port_req       (port_req),
    .port_we        (port_we),
    .port_addr      (port_addr),
    .port_wdata     (port_wdata),
    .port_rdata     (port_rdata),
    .port_done      (port_done),
    .port_err       (port_err),
    .busy           (busy),
    .mem_request    (mem_request),
    .mem_req_type   (mem_req_type),
    .mem_req_addr   (mem_req_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_write_done (mem_write_done),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one command on a port and queue what the DUT should do with it.
  task automatic applyStimulus(input logic p, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [1:0] edone,
                               input logic [1:0] eerr, input logic [15:0] erdata);
    int pi;
    strobe_t s;
    resp_t r;
    pi = p ? 1 : 0;
    port_we[pi] = we;
    port_addr[pi*ADDR_W +: ADDR_W] = addr;
    port_wdata[pi*DATA_W +: DATA_W] = wdata;
    port_req[pi] = 1'b1;
    s.we = we;
    s.addr = addr;
    s.wdata = wdata;
    exp_strobe_q.push_back(s);
    r.done = edone;
    r.err = eerr;
    r.rdata = erdata;
    exp_resp_q.push_back(r);
  endtask

  // Bounded wait for port_done on one port; returns the cycle it was seen.
  task automatic waitDone(input int p, input int budget, output int cdone);
    bit got;
    got = 1'b0;
    cdone = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (port_done[p] === 1'b1) begin
        cdone = cyc;
        got = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
  endtask

  // Memory model: answers a strobe after resp_delay cycles with the flag
  // matching its type, optionally pulsing the opposite flag first.
  initial begin : responder
    logic rtype;
    mem_ready = 1'b0;
    mem_write_done = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_request === 1'b1 && resp_delay > 0) begin
        rtype = mem_req_type;
        for (int k = 1; k <= resp_delay; k++) begin
          @(negedge clk);
          mem_ready = 1'b0;
          mem_write_done = 1'b0;
          if (wrong_flag && k == 1 && resp_delay > 1) begin
            if (rtype) mem_ready = 1'b1;
            else mem_write_done = 1'b1;
            mem_rdata = 16'hDEAD;
          end
          if (k == resp_delay) begin
            if (rtype) mem_write_done = 1'b1;
            else begin
              mem_ready = 1'b1;
              mem_rdata = resp_data;
            end
          end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_write_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every strobe and every done must match the queue.
  always @(negedge clk) begin
    strobe_t s;
    resp_t r;
    if (mon_en) begin
      if (mem_request === 1'b1) begin
        checkOutput("strobe_expected", {31'd0, exp_strobe_q.size() != 0}, 32'd1);
        if (exp_strobe_q.size() != 0) begin
          s = exp_strobe_q.pop_front();
          checkOutput("strobe_type", {31'd0, mem_req_type}, {31'd0, s.we});
          checkOutput("strobe_addr", {16'd0, mem_req_addr}, {16'd0, s.addr});
          if (s.we) checkOutput("strobe_wdata", {16'd0, mem_wdata}, {16'd0, s.wdata});
        end
      end
      if (port_done !== 2'b00) begin
        checkOutput("done_expected", {31'd0, exp_resp_q.size() != 0}, 32'd1);
        if (exp_resp_q.size() != 0) begin
          r = exp_resp_q.pop_front();
          checkOutput("port_done", {30'd0, port_done}, {30'd0, r.done});
          checkOutput("port_err", {30'd0, port_err}, {30'd0, r.err});
          checkOutput("port_rdata", {16'd0, port_rdata}, {16'd0, r.rdata});
        end
      end else if (port_err !== 2'b00) begin
        checkOutput("err_without_done", {30'd0, port_err}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[6];
    int c0;
    int cdone;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2, 2'b01, 2'b00, 16'hBEEF, 4};
    vecs[1] = '{1'b1, 1'b1, 16'h00A0, 16'h1234, 16'h0000, 2, 2'b10, 2'b00, 16'hBEEF, 4};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h9999, 16'h5A5A, 5, 2'b10, 2'b00, 16'h5A5A, 7};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1, 2'b01, 2'b00, 16'h5A5A, 3};
    vecs[4] = '{1'b0, 1'b0, 16'h8001, 16'h0000, 16'h0000, 3, 2'b01, 2'b00, 16'h0000, 5};
    vecs[5] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hFFFF, 2, 2'b10, 2'b00, 16'hFFFF, 4};

    reset = 1'b0;
    port_req = 2'b00;
    port_we = 2'b00;
    port_addr = '0;
    port_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_request", {31'd0, mem_request}, 32'd0);
    checkOutput("rst_port_done", {30'd0, port_done}, 32'd0);
    checkOutput("rst_port_err", {30'd0, port_err}, 32'd0);
    checkOutput("rst_port_rdata", {16'd0, port_rdata}, 32'd0);
    checkOutput("rst_mem_req_addr", {16'd0, mem_req_addr}, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    model_rdata = 16'h0000;

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      resp_delay = vecs[i].delay;
      resp_data = vecs[i].mem_data;
      wrong_flag = 1'b0;
      @(negedge clk);
      c0 = cyc;
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_rdata);
      @(negedge clk);
      checkOutput("busy_in_issue", {31'd0, busy}, 32'd1);
      waitDone(vecs[i].port ? 1 : 0, 60, cdone);
      checkOutput("latency", cdone - c0, vecs[i].exp_lat);
      port_req = 2'b00;
      model_rdata = vecs[i].exp_rdata;
    end

    // Timeout: no completion in time, late flag arrives after the abort
    resp_delay = 20;
    resp_data = 16'h7777;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0000, 2'b10, 2'b10, model_rdata);
    waitDone(1, 60, cdone);
    checkOutput("timeout_latency", cdone - c0, 17);
    port_req = 2'b00;
    repeat (8) @(negedge clk);
    checkOutput("timeout_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("timeout_resp_q_empty", exp_resp_q.size(), 32'd0);

    // Reset while waiting for completion
    resp_delay = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0400, 16'h0000, 2'b01, 2'b00, model_rdata);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_mem_request", {31'd0, mem_request}, 32'd0);
    checkOutput("abort_port_done", {30'd0, port_done}, 32'd0);
    checkOutput("abort_port_err", {30'd0, port_err}, 32'd0);
    exp_resp_q.delete();
    port_req = 2'b00;
    reset = 1'b1;
    model_rdata = 16'h0000;
    resp_delay = 2;
    resp_data = 16'hCAFE;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 16'h0500, 16'h0000, 2'b01, 2'b00, 16'hCAFE);
    waitDone(0, 60, cdone);
    checkOutput("post_abort_latency", cdone - c0, 4);
    port_req = 2'b00;
    model_rdata = 16'hCAFE;

    // Opposite-type flag during a read is ignored
    resp_delay = 3;
    resp_data = 16'h2468;
    wrong_flag = 1'b1;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 16'h0600, 16'h0000, 2'b01, 2'b00, 16'h2468);
    waitDone(0, 60, cdone);
    checkOutput("wrong_flag_latency", cdone - c0, 5);
    port_req = 2'b00;
    wrong_flag = 1'b0;
    model_rdata = 16'h2468;

    // Request dropped right after acceptance still completes
    resp_delay = 2;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 16'h0700, 16'h55AA, 2'b10, 2'b00, model_rdata);
    @(negedge clk);
    port_req = 2'b00;
    waitDone(1, 60, cdone);
    checkOutput("dropped_req_latency", cdone - c0, 4);

    // Ties after reset: port 0, then port 1, then port 0 again
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_rdata = 16'h0000;
    resp_delay = 2;
    resp_data = 16'h1111;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b01, 2'b00, 16'h1111);
    applyStimulus(1'b1, 1'b1, 16'h0200, 16'hABCD, 2'b10, 2'b00, 16'h1111);
    waitDone(0, 60, cdone);
    checkOutput("tie1_p0_latency", cdone - c0, 4);
    port_req[0] = 1'b0;
    waitDone(1, 60, cdone);
    checkOutput("tie1_p1_latency", cdone - c0, 9);
    port_req[1] = 1'b0;
    resp_data = 16'h2222;
    @(negedge clk);
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 16'h0110, 16'h0000, 2'b01, 2'b00, 16'h2222);
    applyStimulus(1'b1, 1'b1, 16'h0210, 16'h4321, 2'b10, 2'b00, 16'h2222);
    waitDone(0, 60, cdone);
    checkOutput("tie2_p0_latency", cdone - c0, 4);
    port_req[0] = 1'b0;
    waitDone(1, 60, cdone);
    checkOutput("tie2_p1_latency", cdone - c0, 9);
    port_req[1] = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("final_strobe_q_empty", exp_strobe_q.size(), 32'd0);
    checkOutput("final_resp_q_empty", exp_resp_q.size(), 32'd0);
    checkOutput("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
